divu_seq: RTL and testbench

DIVU_SEQ -- requirements
Module: divu_seq

---
 rtl/divu_seq.sv | 117 +++++++++++
 tb/tb_divu_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_seq.sv
// Sequential 32-bit unsigned divider (restoring, one quotient bit per cycle).
// Define DIVU_ZERO_FAST_EN to finish a divide-by-zero on the cycle after start.
module divu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        mf_req,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [33:0] rem_sh;
   logic [33:0] diff;
   logic        ge;
   logic [32:0] rem_nx;
   logic [31:0] quo_nx;

   // Bit 33 of the difference is the borrow: clear means rem >= divisor.
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {2'b00, dvsr_q};
   assign ge     = ~diff[33];
   assign rem_nx = ge ? diff[32:0] : rem_sh[32:0];
   assign quo_nx = {quo_q[30:0], ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
`ifdef DIVU_ZERO_FAST_EN
               if (divisor == 32'd0) begin
                  state_d = DONE;
                  hi_d    = dividend;
                  lo_d    = 32'hFFFF_FFFF;
               end else begin
                  state_d = RUN;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = dividend;
                  dvsr_d  = divisor;
               end
`else
               state_d = RUN;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = dividend;
               dvsr_d  = divisor;
`endif
            end
         end
         RUN: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = DONE;
               hi_d    = rem_nx[31:0];
               lo_d    = quo_nx;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign stall = (mf_req | start) & busy;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: cycle-accurate busy/done/stall and HI/LO.
module tb_divu_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        mf_req;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int failures = 0;
   logic [63:0] sb_q[$];

`ifdef DIVU_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   divu_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .mf_req   (mf_req),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [31:0] a,
                                         input logic [31:0] b);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string nm, input logic eb,
                            input logic ed);
      checks++;
      if (busy !== eb) begin
         failures++;
         $display("FAIL %s busy got=%b exp=%b t=%0t", nm, busy, eb, $time);
      end
      checks++;
      if (done !== ed) begin
         failures++;
         $display("FAIL %s done got=%b exp=%b t=%0t", nm, done, ed, $time);
      end
   endtask

   task automatic chk_result(input string nm);
      logic [63:0] e;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard empty at done", nm);
         return;
      end
      e = sb_q.pop_front();
      if ({hi, lo} !== e) begin
         failures++;
         $display("FAIL %s hi/lo got=%h/%h exp=%h/%h", nm, hi, lo,
                  e[63:32], e[31:0]);
      end
   endtask

   // Issues a divide and walks every cycle up to and one past done.
   task automatic do_div(input string nm, input logic [31:0] a,
                         input logic [31:0] b);
      int lat;
      logic [63:0] held;
      lat = (FAST && b == 32'd0) ? 1 : 33;
      start = 1'b1;
      dividend = a;
      divisor = b;
      sb_q.push_back(model(a, b));
      next_cycle();
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      for (int c = 1; c <= lat; c++) begin
         chk_state(nm, (lat == 33) && (c < 33), c == lat);
         if (c == lat) chk_result(nm);
         else next_cycle();
      end
      held = {hi, lo};
      next_cycle();
      chk_state({nm, "_after"}, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== held) begin
         failures++;
         $display("FAIL %s_hold hi/lo got=%h exp=%h", nm, {hi, lo}, held);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      mf_req = 1'b1;
      dividend = '0;
      divisor = '0;
      repeat (2) next_cycle();
      chk_state("reset", 1'b0, 1'b0);
      checks++;
      if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset stall/hi/lo got=%b/%h/%h exp=0/0/0",
                  stall, hi, lo);
      end
      mf_req = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      do_div("div_100_7", 32'd100, 32'd7);
      do_div("div_max_1", 32'hFFFF_FFFF, 32'd1);
      do_div("div_80_max", 32'h8000_0000, 32'hFFFF_FFFF);
      do_div("div_small_big", 32'd5, 32'd9);
      do_div("div_equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++)
         do_div("div_rand", $urandom, $urandom_range(1, 32'h0001_0000));
   endtask

   task automatic test_div_zero();
      do_div("div_zero", 32'h1234, 32'd0);
      do_div("div_zero_0", 32'd0, 32'd0);
   endtask

   task automatic test_mf_stall();
      start = 1'b1;
      dividend = 32'd100;
      divisor = 32'd7;
      sb_q.push_back(model(32'd100, 32'd7));
      next_cycle();
      start = 1'b0;
      for (int c = 1; c <= 33; c++) begin
         mf_req = (c >= 5);
         #1;
         checks++;
         if (stall !== (c >= 5 && c <= 32)) begin
            failures++;
            $display("FAIL mf_stall c=%0d got=%b exp=%b", c, stall,
                     (c >= 5 && c <= 32));
         end
         if (c == 33) begin
            chk_state("mf_done", 1'b0, 1'b1);
            chk_result("mf_done");
         end else begin
            next_cycle();
         end
      end
      mf_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      dividend = 32'h0BAD_CAFE;
      divisor = 32'd3;
      next_cycle();
      start = 1'b0;
      mf_req = 1'b1;
      for (int c = 1; c < 10; c++) next_cycle();
      chk_state("abort_pre", 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk_state("abort_async", 1'b0, 1'b0);
      checks++;
      if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL abort_async stall/hi/lo got=%b/%h/%h exp=0/0/0",
                  stall, hi, lo);
      end
      next_cycle();
      rst = 1'b0;
      mf_req = 1'b0;
      for (int c = 0; c < 40; c++) begin
         next_cycle();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 ||
             lo !== 32'd0) begin
            failures++;
            $display("FAIL abort_after c=%0d done/busy/hi/lo got=%b/%b/%h/%h exp=0/0/0/0",
                     c, done, busy, hi, lo);
         end
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1;
      dividend = 32'd1000;
      divisor = 32'd33;
      sb_q.push_back(model(32'd1000, 32'd33));
      next_cycle();
      start = 1'b0;
      for (int c = 1; c <= 66; c++) begin
         if (c == 20) begin
            start = 1'b1;
            dividend = 32'h0765_4321;
            divisor = 32'd10;
         end
         #1;
         if (c >= 20 && c <= 33) begin
            checks++;
            if (stall !== (c <= 32)) begin
               failures++;
               $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, stall,
                        (c <= 32));
            end
         end
         chk_state("b2b", (c <= 32) || (c >= 34 && c <= 65),
                   (c == 33) || (c == 66));
         if (c == 33) begin
            chk_result("b2b_first");
            sb_q.push_back(model(32'h0765_4321, 32'd10));
         end
         if (c == 66) chk_result("b2b_second");
         else next_cycle();
         if (c == 33) start = 1'b0;
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      do_div("post_reset", 32'd77, 32'd5);
      test_basic();
      test_div_zero();
      test_mf_stall();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
